// File: rtl/endgenerate_blk.sv
// endgenerate_blk: registered WIDTH-bit arithmetic slice, {Cout,D} = A + Y + Cin,
// where Y is B, ~B, all zeros or all ones according to S1:S0.
// Optional status flags (Z, V, N) are built when the macro ALU_FLAGS_EN is defined.
module endgenerate_blk #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             S1,
    input  logic             S0,
    input  logic             Cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] D,
    output logic             Cout
`ifdef ALU_FLAGS_EN
    ,
    output logic             Z,
    output logic             V,
    output logic             N
`endif
);

    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   c;

    // Operand select for the Y input of the adder
    always_comb begin
        y = B;
        unique case ({S1, S0})
            2'b00:   y = B;
            2'b01:   y = ~B;
            2'b10:   y = '0;
            2'b11:   y = '1;
            default: y = B;
        endcase
    end

    assign p    = A ^ y;
    assign g    = A & y;
    assign c[0] = Cin;

    // Ripple carry-propagate chain, one cell per bit
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        assign c[i+1] = g[i] | (p[i] & c[i]);
        assign sum[i] = p[i] ^ c[i];
    end

    // Result register: capture on in_valid, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            D         <= '0;
            Cout      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                D    <= sum;
                Cout <= c[WIDTH];
            end
        end
    end

`ifdef ALU_FLAGS_EN
    // Status flags captured alongside the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Z <= 1'b0;
            V <= 1'b0;
            N <= 1'b0;
        end else if (in_valid) begin
            Z <= (sum == '0);
            V <= c[WIDTH] ^ c[WIDTH-1];
            N <= sum[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_endgenerate_blk.sv
// Directed and exhaustive self-checking bench for endgenerate_blk (WIDTH=4).
// Flag checks are included when ALU_FLAGS_EN is defined.
module tb_endgenerate_blk;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s1;
    logic         s0;
    logic         cin;
    logic         out_valid;
    logic [W-1:0] d;
    logic         cout;
`ifdef ALU_FLAGS_EN
    logic         z;
    logic         v;
    logic         n;
`endif

    int n_cmp;
    int n_err;

    endgenerate_blk #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (a),
        .B         (b),
        .S1        (s1),
        .S0        (s0),
        .Cin       (cin),
        .out_valid (out_valid),
        .D         (d),
        .Cout      (cout)
`ifdef ALU_FLAGS_EN
        ,
        .Z         (z),
        .V         (v),
        .N         (n)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one operation, then check the registered result one edge later
    task automatic run(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input logic [1:0] s, input logic ci,
                       input logic [W-1:0] de, input logic ce);
        @(negedge clk);
        a        = ai;
        b        = bi;
        s1       = s[1];
        s0       = s[0];
        cin      = ci;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 32'(out_valid), 32'(1));
        check({tag, "_res"}, 32'({cout, d}), 32'({ce, de}));
    endtask

    logic [W-1:0] y_m;
    logic [W:0]   r_m;
    logic [W-1:0] hold_d;
    logic         hold_c;

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        s1       = 1'b0;
        s0       = 1'b0;
        cin      = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_d", 32'(d), 32'(0));
        check("rst_cout", 32'(cout), 32'(0));
        check("rst_valid", 32'(out_valid), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        run("add_5_3",    4'd5,  4'd3, 2'b00, 1'b0, 4'd8,  1'b0);
        run("add_15_1",   4'd15, 4'd1, 2'b00, 1'b0, 4'd0,  1'b1);
        run("add_c1",     4'd2,  4'd3, 2'b00, 1'b1, 4'd6,  1'b0);
        run("sub_5_3",    4'd5,  4'd3, 2'b01, 1'b1, 4'd2,  1'b1);
        run("sub_3_5",    4'd3,  4'd5, 2'b01, 1'b1, 4'd14, 1'b0);
        run("sub1_5_3",   4'd5,  4'd3, 2'b01, 1'b0, 4'd1,  1'b1);
        run("xfer_5",     4'd5,  4'd9, 2'b10, 1'b0, 4'd5,  1'b0);
        run("inc_5",      4'd5,  4'd9, 2'b10, 1'b1, 4'd6,  1'b0);
        run("inc_15",     4'd15, 4'd9, 2'b10, 1'b1, 4'd0,  1'b1);
        run("dec_5",      4'd5,  4'd0, 2'b11, 1'b0, 4'd4,  1'b1);
        run("dec_0",      4'd0,  4'd0, 2'b11, 1'b0, 4'd15, 1'b0);
        run("ones_c1",    4'd9,  4'd0, 2'b11, 1'b1, 4'd9,  1'b1);
        run("flag_7_1",   4'd7,  4'd1, 2'b00, 1'b0, 4'd8,  1'b0);
`ifdef ALU_FLAGS_EN
        check("flag_v", 32'(v), 32'(1));
        check("flag_n", 32'(n), 32'(1));
        check("flag_z", 32'(z), 32'(0));
        run("flag_zero",  4'd15, 4'd1, 2'b00, 1'b0, 4'd0,  1'b1);
        check("flagz_z", 32'(z), 32'(1));
        check("flagz_v", 32'(v), 32'(0));
        check("flagz_n", 32'(n), 32'(0));
`endif

        // Hold: in_valid low with changing operands
        hold_d = d;
        hold_c = cout;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            a        = 4'(k * 5 + 3);
            b        = 4'(k * 7 + 1);
            @(posedge clk);
            #1;
            check("hold_valid", 32'(out_valid), 32'(0));
            check("hold_res", 32'({cout, d}), 32'({hold_c, hold_d}));
        end

        // Reset asserted mid-cycle while a capture is pending
        @(negedge clk);
        a        = 4'd5;
        b        = 4'd3;
        s1       = 1'b0;
        s0       = 1'b0;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        check("pre_rst_d", 32'(d), 32'(8));
        rst_n = 1'b0;
        #1;
        check("mid_rst_d", 32'(d), 32'(0));
        check("mid_rst_cout", 32'(cout), 32'(0));
        check("mid_rst_valid", 32'(out_valid), 32'(0));
        @(posedge clk);
        #1;
        check("rst_hold_d", 32'(d), 32'(0));
        check("rst_hold_valid", 32'(out_valid), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_d", 32'(d), 32'(0));
        check("rel_valid", 32'(out_valid), 32'(0));
        @(posedge clk);
        #1;
        check("first_cap", 32'({cout, d}), 32'({1'b0, 4'd8}));

        // Exhaustive sweep against a behavioural model
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int si = 0; si < 4; si++) begin
                    for (int ci = 0; ci < 2; ci++) begin
                        @(negedge clk);
                        a        = 4'(ai);
                        b        = 4'(bi);
                        s1       = 1'(si >> 1);
                        s0       = 1'(si);
                        cin      = 1'(ci);
                        in_valid = 1'b1;
                        case (si)
                            0:       y_m = 4'(bi);
                            1:       y_m = ~4'(bi);
                            2:       y_m = 4'd0;
                            default: y_m = 4'hF;
                        endcase
                        r_m = 5'(ai) + 5'(y_m) + 5'(ci);
                        @(posedge clk);
                        #1;
                        check("sweep", 32'({out_valid, cout, d}), 32'({1'b1, r_m}));
`ifdef ALU_FLAGS_EN
                        check("sweep_z", 32'(z), 32'(r_m[3:0] == 4'd0));
                        check("sweep_n", 32'(n), 32'(r_m[3]));
                        check("sweep_v", 32'(v),
                              32'((4'(ai) >> 3) == (y_m >> 3) && r_m[3] != 1'(4'(ai) >> 3)));
`endif
                    end
                end
            end
        end

        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("end_valid", 32'(out_valid), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
